parallax_layers: RTL and testbench
==================================

PARALLAX_LAYERS -- requirements
Module: parallax_layers

Interface
REQ-001 Parameters SHALL be: H_VIS=640, H_FP=16, H_SYNC=96, H_BP=48, V_VIS=480, V_FP=10, V_SYNC=2, V_BP=33 (VGA timing); LAYERS=3, legal range 1..4 (parallax layer count); RGB_W=1 (bits per colour channel).
REQ-002 clk  input  1  pixel clock.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 speed  input  4*LAYERS  per-layer scroll step in pixels/frame; layer k uses bits [4k+3:4k].
REQ-005 hsync  output  1  horizontal sync, active low.
REQ-006 vsync  output  1  vertical sync, active low.
REQ-007 rgb  output  3*RGB_W  pixel colour {R,G,B}.
REQ-008 frame_start  output  1  one-cycle pulse aligned with pixel (0,0).

Function
REQ-009 Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1) SHALL be used, with H_TOTAL=H_VIS+H_FP+H_SYNC+H_BP and V_TOTAL likewise; h increments every clk; at H_TOTAL-1, h wraps to 0 and v increments; v wraps to 0 after V_TOTAL-1.
REQ-010 All outputs SHALL be registered, with one-cycle latency from the counter state that produces them.
REQ-011 hsync SHALL be low iff H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC; vsync SHALL be low iff V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC.
REQ-012 rgb SHALL be 0 whenever h>=H_VIS or v>=V_VIS.
REQ-013 Each layer k SHALL have an 11-bit offset off_k; at counter state (H_TOTAL-1, V_TOTAL-1), off_k <= off_k + speed[k] modulo 2048, so that 2047+1 wraps to 0.
REQ-014 speed SHALL be sampled only at the frame-end update cycle; changes mid-frame SHALL NOT affect the current frame.
REQ-015 Layer k SHALL be lit iff v >= (V_VIS >> (k+1)) and bit (k+4) of the 11-bit sum (h + off_k) is 0.
REQ-016 Priority: the lowest lit k SHALL win; its colour index is k+1 (3-bit {R,G,B}); each bit is replicated RGB_W times per channel; no lit layer gives rgb=0.
REQ-017 frame_start SHALL be 1 for exactly the output cycle corresponding to h=0, v=0.

Reset
REQ-018 While reset_n=0 at a clk edge: h=0, v=0, all off_k=0, hsync=1, vsync=1, rgb=0, frame_start=0.
REQ-019 Reset asserted mid-frame SHALL abort the frame; the first output cycle after release SHALL correspond to (0,0), with frame_start=1.

Configuration
REQ-020 Macro PARALLAX_PAUSE_EN defined: an extra input pause (1 bit) SHALL exist; if pause=1 at the frame-end update cycle, all offsets hold; timing is unaffected.
REQ-021 Macro PARALLAX_PAUSE_EN undefined: the pause port SHALL be absent and offsets SHALL update every frame.

Structure
REQ-022 Package parallax_pkg SHALL hold the default VGA timing constants, the offset width (11), and a colour-index-to-rgb expansion function.
REQ-023 Sub-module vga_timing SHALL contain the h/v counters and the raw sync/visible/frame-end decode; parallax_layers instantiates it and adds the offsets, the layer compare, and the output registers.

Verification
REQ-024 Reset, defaults, speed=0: hsync low for output cycles of h=656..751; vsync low for v=490..491; frame period is 800*525 = 420000 clk.
REQ-025 speed=0, v=240: h=0..15 -> rgb=001; h=16..31 -> 010; v=100, h=0..63 -> 011; v=50 -> rgb=000 throughout.
REQ-026 speed[3:0]=3, after one frame_start: v=240, h=13 -> rgb=010 (layer0 off since 13+3=16 has bit4 set).
REQ-027 speed=4'hF on layer0 for 137 frames: off_0 = 2055 mod 2048 = 7; verify wrap and pattern at h=9 -> rgb=010.
REQ-028 Assert reset_n=0 for 1 clk at v=300; after release, the first output cycle has frame_start=1, hsync=vsync=1, and offsets are 0.
REQ-029 With PARALLAX_PAUSE_EN, pause=1 across a frame-end and speed=5: off_0 is unchanged; with pause=0 at the next frame-end, off_0 = 5.

Source files
------------

// File: rtl/parallax_pkg.sv
// Shared constants for the parallax scroller: default VGA 640x480 timing, the
// layer offset width, and the colour-index-to-rgb bit expansion.
package parallax_pkg;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int OFF_W = 11;

    // Bit 'pos' of the expanded {R,G,B} word; each index bit fills w channel bits.
    function automatic logic rgb_bit(input logic [2:0] idx, input int pos, input int w);
        return idx[2'(pos / w)];
    endfunction

endpackage

// File: rtl/parallax_if.sv
// Video bundle between the parallax generator (master) and its sink (slave).
// Optional pause input exists only when PARALLAX_PAUSE_EN is defined.
interface parallax_if #(
    parameter int LAYERS = 3,
    parameter int RGB_W  = 1
);
    logic [4*LAYERS-1:0] speed;
`ifdef PARALLAX_PAUSE_EN
    logic                pause;
`endif
    logic                hsync;
    logic                vsync;
    logic [3*RGB_W-1:0]  rgb;
    logic                frame_start;

    modport master (
`ifdef PARALLAX_PAUSE_EN
        input  pause,
`endif
        input  speed,
        output hsync,
        output vsync,
        output rgb,
        output frame_start
    );

    modport slave (
`ifdef PARALLAX_PAUSE_EN
        output pause,
`endif
        output speed,
        input  hsync,
        input  vsync,
        input  rgb,
        input  frame_start
    );
endinterface

// File: rtl/parallax_layers_vga_timing.sv
// Free-running h/v raster counters with combinational sync/visible/frame decode.
// Latency: decode is same-cycle from the counters; no backpressure (pixel clock paced).
module vga_timing #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int HW = $clog2(H_TOTAL),
    localparam int VW = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          visible,
    output logic          frame_end,
    output logic          frame_origin
);

    logic h_last;
    logic v_last;

    assign h_last = (h == HW'(H_TOTAL - 1));
    assign v_last = (v == VW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign hsync_raw    = !((h >= HW'(H_VIS + H_FP)) && (h < HW'(H_VIS + H_FP + H_SYNC)));
    assign vsync_raw    = !((v >= VW'(V_VIS + V_FP)) && (v < VW'(V_VIS + V_FP + V_SYNC)));
    assign visible      = (h < HW'(H_VIS)) && (v < VW'(V_VIS));
    assign frame_end    = h_last && v_last;
    assign frame_origin = (h == '0) && (v == '0);

endmodule

// File: rtl/parallax_layers.sv
// Parallax stripe generator: up to 4 scrolling layers over VGA timing (PARALLAX_PAUSE_EN adds pause).
// Latency: outputs registered one cycle after the raster state; no backpressure (pixel clock paced).
module parallax_layers
    import parallax_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF,
    parameter int LAYERS = 3,
    parameter int RGB_W  = 1,
    localparam int HW = $clog2(H_VIS + H_FP + H_SYNC + H_BP),
    localparam int VW = $clog2(V_VIS + V_FP + V_SYNC + V_BP)
) (
    input  logic      clk,
    input  logic      reset_n,
    parallax_if.master bus
);

    logic [HW-1:0]      h;
    logic [VW-1:0]      v;
    logic               hsync_raw;
    logic               vsync_raw;
    logic               visible;
    logic               frame_end;
    logic               frame_origin;
    logic [OFF_W-1:0]   off [LAYERS];
    logic [OFF_W-1:0]   sum;
    logic [2:0]         idx;
    logic [3*RGB_W-1:0] rgb_next;
    logic               advance;

    vga_timing #(
        .H_VIS (H_VIS),  .H_FP  (H_FP),  .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS),  .V_FP  (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk          (clk),
        .reset_n      (reset_n),
        .h            (h),
        .v            (v),
        .hsync_raw    (hsync_raw),
        .vsync_raw    (vsync_raw),
        .visible      (visible),
        .frame_end    (frame_end),
        .frame_origin (frame_origin)
    );

`ifdef PARALLAX_PAUSE_EN
    assign advance = frame_end && !bus.pause;
`else
    assign advance = frame_end;
`endif

    // speed is only looked at here, so mid-frame changes cannot disturb the frame being drawn
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < LAYERS; k++) off[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k < LAYERS; k++) off[k] <= off[k] + OFF_W'(bus.speed[4*k +: 4]);
        end
    end

    // Walk from the back layer forward so the lowest lit layer overwrites the rest.
    always_comb begin
        idx = '0;
        sum = '0;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            sum = OFF_W'(h) + off[k];
            if ((int'(v) >= (V_VIS >> (k + 1))) && !sum[k + 4]) idx = 3'(k + 1);
        end
        rgb_next = '0;
        for (int i = 0; i < 3 * RGB_W; i++) rgb_next[i] = rgb_bit(idx, i, RGB_W);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.rgb         <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.hsync       <= hsync_raw;
            bus.vsync       <= vsync_raw;
            bus.rgb         <= visible ? rgb_next : '0;
            bus.frame_start <= frame_origin;
        end
    end

endmodule

// File: tb/tb_parallax_layers.sv
// Bench for parallax_layers on a shrunken raster; every output cycle is compared
// against a pixel-index reference model, plus targeted pattern/reset checks.
module tb_parallax_layers;

    localparam int H_VIS = 20, H_FP = 1, H_SYNC = 2, H_BP = 1;
    localparam int V_VIS = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int LAYERS = 3, RGB_W = 1;
    localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    parallax_if #(.LAYERS(LAYERS), .RGB_W(RGB_W)) bus ();

    parallax_layers #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .LAYERS(LAYERS), .RGB_W(RGB_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;   // output cycle index since reset release
    int cyc      = 0;
    int last_fs  = -1;
    int moff [LAYERS];
    logic [2:0] pix [V_VIS][H_VIS];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // {frame_start, hsync, vsync, rgb} for raster position (h, v) under current model offsets.
    function automatic logic [5:0] model_out(input int h, input int v);
        logic [2:0] col;
        logic hs, vs;
        col = 3'd0;
        if (h < H_VIS && v < V_VIS) begin
            for (int k = LAYERS - 1; k >= 0; k--) begin
                int s;
                s = (h + moff[k]) % 2048;
                if (v >= (V_VIS >> (k + 1)) && ((s / (16 << k)) % 2) == 0) col = 3'(k + 1);
            end
        end
        hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
        vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        return {(h == 0 && v == 0), hs, vs, col};
    endfunction

    task automatic step();
        int h, v;
        logic [5:0] exp;
        logic paused;
        h = n % HT;
        v = (n / HT) % VT;
        exp = model_out(h, v);
        @(posedge clk);
        #1;
        cyc++;
        check_eq("pixel", {26'd0, bus.frame_start, bus.hsync, bus.vsync, bus.rgb}, {26'd0, exp});
        if (h < H_VIS && v < V_VIS) pix[v][h] = bus.rgb;
        if (bus.frame_start) begin
            if (last_fs >= 0) check_eq("frame_period", cyc - last_fs, FRAME);
            last_fs = cyc;
        end
`ifdef PARALLAX_PAUSE_EN
        paused = bus.pause;
`else
        paused = 1'b0;
`endif
        if (h == HT - 1 && v == VT - 1 && !paused)
            for (int k = 0; k < LAYERS; k++)
                moff[k] = (moff[k] + int'(bus.speed[4*k +: 4])) % 2048;
        n++;
    endtask

    task automatic run_cycles(input int cnt, input bit rnd);
        for (int i = 0; i < cnt; i++) begin
            if (rnd && $urandom_range(0, 31) == 0) bus.speed = 12'($urandom);
            step();
        end
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_eq("reset_outputs", {28'd0, bus.frame_start, bus.hsync, bus.vsync, bus.rgb},
                     {28'd0, 1'b0, 1'b1, 1'b1, 3'd0});
        end
        reset_n = 1'b1;
        n = 0;
        last_fs = -1;
        for (int k = 0; k < LAYERS; k++) moff[k] = 0;
    endtask

    initial begin
        bus.speed = '0;
`ifdef PARALLAX_PAUSE_EN
        bus.pause = 1'b0;
`endif
        do_reset(2);

        // static frame, all offsets zero
        run_cycles(FRAME, 1'b0);
        check_eq("s0_v4_h0",  pix[4][0],  3'b001);
        check_eq("s0_v4_h15", pix[4][15], 3'b001);
        check_eq("s0_v4_h16", pix[4][16], 3'b010);
        check_eq("s0_v4_h19", pix[4][19], 3'b010);
        check_eq("s0_v2_h10", pix[2][10], 3'b010);
        check_eq("s0_v1_h5",  pix[1][5],  3'b011);
        check_eq("s0_v0_h5",  pix[0][5],  3'b000);

        // layer0 speed 3 takes effect from the next frame boundary
        bus.speed = 12'h003;
        run_cycles(FRAME, 1'b0);
        check_eq("s3_pre_v4_h13", pix[4][13], 3'b001);
        run_cycles(FRAME, 1'b0);
        check_eq("s3_v4_h13", pix[4][13], 3'b010);
        check_eq("s3_v4_h12", pix[4][12], 3'b001);

        // 137 frame-ends at speed 15: offset 2055 wraps to 7
        bus.speed = '0;
        do_reset(1);
        bus.speed = 12'h00F;
        run_cycles(138 * FRAME, 1'b0);
        check_eq("wrap_v4_h9", pix[4][9], 3'b010);
        check_eq("wrap_v4_h8", pix[4][8], 3'b001);

        // reset mid-frame (v=5) restarts at the origin with zero offsets
        run_cycles(5 * HT + 7, 1'b0);
        do_reset(1);
        step();
        check_eq("post_reset_fs", bus.frame_start, 1'b1);
        check_eq("post_reset_sync", {bus.hsync, bus.vsync}, 2'b11);
        run_cycles(FRAME - 1, 1'b0);
        check_eq("post_reset_v4_h10", pix[4][10], 3'b001);

        // random speeds changed at arbitrary points in the frame
        run_cycles(8 * FRAME, 1'b1);

`ifdef PARALLAX_PAUSE_EN
        bus.speed = '0;
        do_reset(1);
        bus.speed = 12'h005;
        bus.pause = 1'b1;
        run_cycles(FRAME, 1'b0);
        bus.pause = 1'b0;
        run_cycles(FRAME, 1'b0);
        check_eq("pause_held_v4_h11", pix[4][11], 3'b001);
        run_cycles(FRAME, 1'b0);
        check_eq("pause_released_v4_h11", pix[4][11], 3'b010);
        for (int i = 0; i < 4; i++) begin
            bus.pause = 1'($urandom);
            run_cycles(FRAME, 1'b1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
